call_return_unit: RTL and testbench
===================================

// Module: call_return_unit
// PURPOSE
// - Initiator side of the stack push/pop interface: sequences CALL (save return PC) and
//   RET (restore return PC) for the CPU control unit.
// - Drives the push/pop strobes of the stack pointer block and the write/read of the stack RAM.
// - Stack grows downward; the stack pointer supplies the RAM address.
// - The stack RAM is synchronous-read, with data one cycle after address.
// PARAMETERS
// - ADDR_WIDTH  8  stack address width; capacity = 2**ADDR_WIDTH entries
// - DATA_WIDTH  8  return-PC width (stack word width)
// PORTS
// - clk          in   1           rising-edge clock
// - rst_n        in   1           asynchronous active-low reset
// - call_valid   in   1           CALL request; held until accepted
// - call_pc      in   DATA_WIDTH  return address to save; sampled on accept
// - ret_valid    in   1           RET request; held until accepted
// - ready        out  1           unit idle; a request is accepted when valid && ready
// - done         out  1           1-cycle pulse: operation finished
// - err          out  1           1-cycle pulse with done: overflow/underflow (guard only)
// - ret_pc       out  DATA_WIDTH  popped return address; valid from done, held until next RET
// - depth        out  ADDR_WIDTH+1 entries on stack, 0..2**ADDR_WIDTH (guard only, else 0)
// - sp_push      out  1           push strobe to stack pointer
// - sp_pop       out  1           pop strobe to stack pointer
// - ram_we       out  1           stack RAM write enable (address = stack pointer addr)
// - ram_wdata    out  DATA_WIDTH  stack RAM write data
// - ram_rdata    in   DATA_WIDTH  stack RAM read data, valid one cycle after pop cycle
// BEHAVIOUR
// Reset
// - On reset, the unit is in IDLE with ready=1 and depth=0.
// - All other outputs are 0: done, err, ret_pc, sp_push, sp_pop, ram_we, ram_wdata.
// - Reset mid-operation aborts immediately; no strobe is issued after reset.
// - The top level resets the stack pointer from the same rst_n (inverted), so SP returns to all-ones.
// FSM: IDLE, PUSH, POP, CAPT, FIN. ready=1 only in IDLE.
// - IDLE -> PUSH on call_valid; latch call_pc.
// - IDLE -> POP on ret_valid && !call_valid.
// - CALL has priority when both are valid; RET stays pending and is taken next IDLE.
// - PUSH: sp_push=1, ram_we=1, ram_wdata=latched PC for exactly one cycle; depth+1; -> FIN.
// - POP: sp_pop=1 for one cycle (RAM samples addr=SP+1); depth-1; -> CAPT.
// - CAPT: ret_pc <= ram_rdata; -> FIN.
// - FIN: done=1 (err per guard); -> IDLE.
// - sp_push and sp_pop are never both 1; each is high at most one cycle per operation.
// Latency (accept edge = cycle 0)
// - CALL: strobes in cycle 1; done in cycle 2; next accept possible in cycle 3.
// - RET: pop in cycle 1; ret_pc updated and done in cycle 3.
// Width rules
// - depth is ADDR_WIDTH+1 bits, unsigned, and never wraps when the guard is enabled.
// CONFIGURATION
// - Macro CRU_GUARD_EN defined:
//   - CALL with depth==2**ADDR_WIDTH goes PUSH-less IDLE->FIN with err=1; no strobes; depth and SP unchanged.
//   - RET with depth==0 goes POP-less IDLE->FIN with err=1; ret_pc unchanged.
// - Macro CRU_GUARD_EN undefined:
//   - No depth counter; depth tied 0 and err tied 0.
//   - Every request strobes; the stack pointer wraps modulo 2**ADDR_WIDTH.
// TESTING (ADDR_WIDTH=8, DATA_WIDTH=8)
// - Reset then CALL pc=0x3C -> cycle1 sp_push=1, ram_we=1, ram_wdata=0x3C; cycle2 done=1; depth=1.
// - CALL 0x11, CALL 0x22, RET, RET -> ret_pc 0x22 then 0x11 (LIFO); done 3 cycles after each RET accept; depth 0.
// - call_valid and ret_valid high together, depth=0 -> CALL taken first, then RET returns the same PC; no err.
// - Guard: RET at depth 0 -> done=1, err=1, no sp_pop; 256 CALLs then CALL -> err=1, no sp_push, depth=256.
// - rst_n low during POP cycle -> sp_pop=0 at once, ready=1, depth=0, no done pulse after release.

Source files
------------

// File: rtl/call_return_unit.sv
// call_return_unit: sequences CALL (push return PC) and RET (pop return PC)
// against a downward-growing stack whose pointer block addresses a
// synchronous-read stack RAM. Optional overflow/underflow guard and depth
// counter are enabled by defining CRU_GUARD_EN.
module call_return_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call_valid,
    input  logic [DATA_WIDTH-1:0] call_pc,
    input  logic                  ret_valid,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] ret_pc,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  sp_push,
    output logic                  sp_pop,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        CAPT,
        FIN
    } state_t;

    state_t state;

`ifdef CRU_GUARD_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] depth_q;
    logic                err_q;
    logic                full;
    logic                empty;

    assign full  = (depth_q == DEPTH_MAX);
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    assign err   = err_q;
`else
    assign depth = '0;
    assign err   = 1'b0;
`endif

    // Control FSM; every output is a register set on the transition into the
    // state that owns it, so strobes appear exactly one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            ret_pc    <= '0;
            sp_push   <= 1'b0;
            sp_pop    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
`ifdef CRU_GUARD_EN
            depth_q   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            sp_push <= 1'b0;
            sp_pop  <= 1'b0;
            ram_we  <= 1'b0;
`ifdef CRU_GUARD_EN
            err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // CALL wins over a simultaneous RET; RET stays pending.
                    if (call_valid) begin
                        ready <= 1'b0;
`ifdef CRU_GUARD_EN
                        if (full) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            state     <= PUSH;
                            sp_push   <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_wdata <= call_pc;
                        end
`else
                        state     <= PUSH;
                        sp_push   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_wdata <= call_pc;
`endif
                    end else if (ret_valid) begin
                        ready <= 1'b0;
`ifdef CRU_GUARD_EN
                        if (empty) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            state  <= POP;
                            sp_pop <= 1'b1;
                        end
`else
                        state  <= POP;
                        sp_pop <= 1'b1;
`endif
                    end
                end
                PUSH: begin
                    ram_wdata <= '0;
                    done      <= 1'b1;
                    state     <= FIN;
`ifdef CRU_GUARD_EN
                    depth_q   <= depth_q + 1'b1;
`endif
                end
                POP: begin
                    state <= CAPT;
`ifdef CRU_GUARD_EN
                    depth_q <= depth_q - 1'b1;
`endif
                end
                CAPT: begin
                    // RAM data for the pop address is valid in this cycle.
                    ret_pc <= ram_rdata;
                    done   <= 1'b1;
                    state  <= FIN;
                end
                FIN: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_return_unit.sv
// Testbench for call_return_unit: models the stack pointer and stack RAM,
// keeps a LIFO reference of saved return addresses, and checks directed
// plus randomized CALL/RET sequences. Guard checks run when CRU_GUARD_EN
// is defined.
module tb_call_return_unit;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          call_valid = 1'b0;
    logic [DW-1:0] call_pc = '0;
    logic          ret_valid = 1'b0;
    logic          ready;
    logic          done;
    logic          err;
    logic [DW-1:0] ret_pc;
    logic [AW:0]   depth;
    logic          sp_push;
    logic          sp_pop;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    call_return_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .call_valid(call_valid), .call_pc(call_pc),
        .ret_valid(ret_valid), .ready(ready), .done(done), .err(err),
        .ret_pc(ret_pc), .depth(depth), .sp_push(sp_push), .sp_pop(sp_pop),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Stack pointer (points at next free slot, grows down) and sync-read RAM.
    logic [AW-1:0] sp;
    logic [DW-1:0] mem [CAP];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '1;
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[sp] <= ram_wdata;
            if (sp_push) sp <= sp - 1'b1;
            if (sp_pop) begin
                ram_rdata <= mem[sp + 1'b1];
                sp <= sp + 1'b1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] stk[$];
    logic [DW-1:0] last_ret = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ready !== 1'b1) check(tag, {31'd0, ready}, 32'd1);
    endtask

    function automatic logic [31:0] exp_depth();
`ifdef CRU_GUARD_EN
        return stk.size();
`else
        return 0;
`endif
    endfunction

    task automatic do_call(input logic [DW-1:0] pc);
        call_valid = 1'b1;
        call_pc = pc;
        wait_ready("call_ready_timeout");
        step();
        call_valid = 1'b0;
        call_pc = DW'($urandom);
`ifdef CRU_GUARD_EN
        if (stk.size() == CAP) begin
            check("ovf_done", {31'd0, done}, 32'd1);
            check("ovf_err", {31'd0, err}, 32'd1);
            check("ovf_no_push", {31'd0, sp_push | ram_we}, 32'd0);
            step();
            check("ovf_ready", {31'd0, ready}, 32'd1);
            check("ovf_depth", {23'd0, depth}, exp_depth());
            return;
        end
`endif
        check("call_push", {31'd0, sp_push}, 32'd1);
        check("call_we", {31'd0, ram_we}, 32'd1);
        check("call_wdata", {24'd0, ram_wdata}, {24'd0, pc});
        check("call_no_pop", {31'd0, sp_pop}, 32'd0);
        check("call_busy", {31'd0, ready | done}, 32'd0);
        stk.push_back(pc);
        step();
        check("call_done", {31'd0, done}, 32'd1);
        check("call_err", {31'd0, err}, 32'd0);
        check("call_push_once", {31'd0, sp_push | ram_we}, 32'd0);
        step();
        check("call_ready_after", {31'd0, ready}, 32'd1);
        check("call_done_pulse", {31'd0, done}, 32'd0);
        check("call_depth", {23'd0, depth}, exp_depth());
    endtask

    task automatic do_ret();
        logic [DW-1:0] exp_pc;
        ret_valid = 1'b1;
        wait_ready("ret_ready_timeout");
        step();
        ret_valid = 1'b0;
`ifdef CRU_GUARD_EN
        if (stk.size() == 0) begin
            check("unf_done", {31'd0, done}, 32'd1);
            check("unf_err", {31'd0, err}, 32'd1);
            check("unf_no_pop", {31'd0, sp_pop}, 32'd0);
            step();
            check("unf_ret_pc", {24'd0, ret_pc}, {24'd0, last_ret});
            check("unf_ready", {31'd0, ready}, 32'd1);
            return;
        end
`endif
        exp_pc = stk.pop_back();
        check("ret_pop", {31'd0, sp_pop}, 32'd1);
        check("ret_no_push", {31'd0, sp_push | ram_we}, 32'd0);
        step();
        check("ret_early_done", {31'd0, done | sp_pop}, 32'd0);
        check("ret_pc_held", {24'd0, ret_pc}, {24'd0, last_ret});
        step();
        check("ret_done", {31'd0, done}, 32'd1);
        check("ret_err", {31'd0, err}, 32'd0);
        check("ret_pc", {24'd0, ret_pc}, {24'd0, exp_pc});
        last_ret = exp_pc;
        step();
        check("ret_ready_after", {31'd0, ready}, 32'd1);
        check("ret_depth", {23'd0, depth}, exp_depth());
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_strobes", {28'd0, done, err, sp_push, sp_pop}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_ret_pc", {24'd0, ret_pc}, 32'd0);
        check("rst_depth", {23'd0, depth}, 32'd0);
        rst_n = 1'b1;
        step();

        do_call(8'h3C);
        do_ret();

        do_call(8'h11);
        do_call(8'h22);
        do_ret();
        do_ret();

        // Both requests together at depth 0: CALL first, RET follows.
        ret_valid = 1'b1;
        do_call(8'hA7);
        do_ret();

        for (int i = 0; i < 60; i++) begin
            if (stk.size() == 0 || (stk.size() < 200 && $urandom_range(1, 0) == 1))
                do_call(DW'($urandom));
            else
                do_ret();
        end
        while (stk.size() > 0) do_ret();

`ifdef CRU_GUARD_EN
        do_ret();
        while (stk.size() < CAP) do_call(DW'($urandom));
        check("full_depth", {23'd0, depth}, 32'd256);
        do_call(8'h99);
        do_ret();
        do_ret();
`endif

        // Reset asserted during the POP cycle.
        do_call(8'h5A);
        ret_valid = 1'b1;
        wait_ready("rst_ret_ready_timeout");
        step();
        check("rst_mid_pop", {31'd0, sp_pop}, 32'd1);
        rst_n = 1'b0;
        #1;
        ret_valid = 1'b0;
        stk.delete();
        last_ret = '0;
        check("rst_mid_pop_clear", {31'd0, sp_pop}, 32'd0);
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_depth", {23'd0, depth}, 32'd0);
        check("rst_mid_ret_pc", {24'd0, ret_pc}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_quiet", {29'd0, done, sp_push, sp_pop}, 32'd0);
        end

        do_call(8'hC3);
        do_ret();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
